gaussian_urng: RTL and testbench

- Uniform 64-bit random word source for the Gaussian sampler pipeline; drives the sampler's `valid_in`/`data_in` input stream.
- Implements xoshiro256** with a 256-bit state, loaded from a serial 32-bit seed port.
- Discards a configurable number of warm-up outputs, then emits one word per enabled cycle with registered valid/data.

---
 rtl/gaussian_urng_if.sv | 19 +
 rtl/gaussian_urng.sv | 134 +++++++++++++
 tb/tb_gaussian_urng.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gaussian_urng_if.sv
// Seed load / output stream bundle for gaussian_urng.
interface gaussian_urng_if;
  logic        seed_valid;
  logic [31:0] seed_data;
  logic        en;
  logic        ready;
  logic        valid_out;
  logic [63:0] data_out;

  modport master (
    output seed_valid, seed_data, en,
    input  ready, valid_out, data_out
  );

  modport slave (
    input  seed_valid, seed_data, en,
    output ready, valid_out, data_out
  );
endinterface

// File: rtl/gaussian_urng.sv
// xoshiro256** uniform 64-bit word source: serial seed load, warm-up
// discard, then one registered word per enabled cycle.
module gaussian_urng #(
  parameter int unsigned WARMUP   = 16,
  parameter logic [63:0] ZERO_FIX = 64'h9E3779B97F4A7C15
) (
  input  logic            clk,
  input  logic            rstn,
  gaussian_urng_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, WARM, RUN} state_e;

  localparam int unsigned   WW        = $clog2(WARMUP + 2);
  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP - 1);

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [WW-1:0] warm_q, warm_d;
  logic [63:0]   s_q [4];
  logic [63:0]   s_d [4];
  logic          valid_q, valid_d;
  logic [63:0]   data_q, data_d;

  logic [63:0] nxt [4];
  logic [63:0] result;
  logic [63:0] m5, r7, t, n2a, n3a;
  logic        load;
  logic [2:0]  widx;
  logic        last_word;
  logic        all_zero;

  // One xoshiro256** step from the current state; result uses pre-update s1.
  always_comb begin
    m5     = (s_q[1] << 2) + s_q[1];
    r7     = {m5[56:0], m5[63:57]};
    result = (r7 << 3) + r7;
    t      = s_q[1] << 17;
    n2a    = s_q[2] ^ s_q[0];
    n3a    = s_q[3] ^ s_q[1];
    nxt[1] = s_q[1] ^ n2a;
    nxt[0] = s_q[0] ^ n3a;
    nxt[2] = n2a ^ t;
    nxt[3] = {n3a[18:0], n3a[63:19]};
  end

  // Zero check covers the seven stored words plus the word arriving now.
  assign all_zero = ~|{s_q[0], s_q[1], s_q[2], s_q[3][31:0], bus.seed_data};

  // Next-state, seed write, state update and output register inputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    warm_d    = warm_q;
    s_d       = s_q;
    valid_d   = 1'b0;
    data_d    = data_q;
    load      = 1'b0;
    widx      = 3'd0;
    last_word = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.seed_valid) begin
          load    = 1'b1;
          cnt_d   = 3'd1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (bus.seed_valid) begin
          load  = 1'b1;
          widx  = cnt_q;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            last_word = 1'b1;
            warm_d    = '0;
            state_d   = (WARMUP == 0) ? RUN : WARM;
          end
        end
      end
      WARM: begin
        if (bus.seed_valid) begin
          load    = 1'b1;
          cnt_d   = 3'd1;
          state_d = LOAD;
        end else begin
          s_d    = nxt;
          warm_d = warm_q + WW'(1);
          if (warm_q == WARM_LAST) state_d = RUN;
        end
      end
      RUN: begin
        if (bus.seed_valid) begin
          load    = 1'b1;
          cnt_d   = 3'd1;
          state_d = LOAD;
        end else if (bus.en) begin
          s_d     = nxt;
          valid_d = 1'b1;
          data_d  = result;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) s_d[widx[2:1]][{widx[0], 5'b0} +: 32] = bus.seed_data;
    if (last_word && all_zero) s_d[0] = ZERO_FIX;
  end

  // Registered state, generator words and output stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      warm_q  <= '0;
      s_q     <= '{default: '0};
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      warm_q  <= warm_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.ready     = (state_q == RUN);
  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;

endmodule

// File: tb/tb_gaussian_urng.sv
// Scoreboard bench for gaussian_urng (WARMUP=0 and WARMUP=16 instances).
module tb_gaussian_urng;

  localparam logic [63:0] ZF = 64'h9E3779B97F4A7C15;

  typedef struct {
    int unsigned cyc;
    logic [63:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  gaussian_urng_if ifa();
  gaussian_urng_if ifb();

  gaussian_urng #(.WARMUP(0), .ZERO_FIX(ZF)) dut_a (
    .clk(clk), .rstn(rstn), .bus(ifa.slave)
  );
  gaussian_urng #(.WARMUP(16), .ZERO_FIX(ZF)) dut_b (
    .clk(clk), .rstn(rstn), .bus(ifb.slave)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  exp_t        qa[$];
  exp_t        qb[$];
  logic [63:0] ma [4];
  logic [63:0] mb [4];
  logic [63:0] last_a = '0;
  logic [63:0] last_b = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] x, input int k);
    return (x << k) | (x >> (64 - k));
  endfunction

  // Reference xoshiro256** step.
  task automatic xo(inout logic [63:0] s0, inout logic [63:0] s1,
                    inout logic [63:0] s2, inout logic [63:0] s3,
                    output logic [63:0] r);
    logic [63:0] t;
    r  = rotl(s1 * 64'd5, 7) * 64'd9;
    t  = s1 << 17;
    s2 = s2 ^ s0;
    s3 = s3 ^ s1;
    s1 = s1 ^ s2;
    s0 = s0 ^ s3;
    s2 = s2 ^ t;
    s3 = rotl(s3, 45);
  endtask

  // Monitor A: every valid word must match the head of the queue at the
  // expected cycle; data must hold while valid is low.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) last_a = '0;
    else if (ifa.valid_out === 1'b1) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_valid: got data %h expected no valid", ifa.data_out);
      end else begin
        e = qa.pop_front();
        chk("a_data", ifa.data_out, e.d);
        chk("a_latency", 64'(cyc), 64'(e.cyc));
      end
      last_a = ifa.data_out;
    end else chk("a_hold", ifa.data_out, last_a);
  end

  // Monitor B, same rules.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) last_b = '0;
    else if (ifb.valid_out === 1'b1) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_valid: got data %h expected no valid", ifb.data_out);
      end else begin
        e = qb.pop_front();
        chk("b_data", ifb.data_out, e.d);
        chk("b_latency", 64'(cyc), 64'(e.cyc));
      end
      last_b = ifb.data_out;
    end else chk("b_hold", ifb.data_out, last_b);
  end

  // Drive n seed words (word i = w[32*i +: 32]); on a full load, seed the model.
  task automatic seed(input bit sel, input logic [255:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel) begin ifb.seed_valid = 1'b1; ifb.seed_data = w[32*i +: 32]; end
      else     begin ifa.seed_valid = 1'b1; ifa.seed_data = w[32*i +: 32]; end
      @(posedge clk); #1;
      if (i == 0) chk(sel ? "b_ready_after_word0" : "a_ready_after_word0",
                      64'(sel ? ifb.ready : ifa.ready), 64'd0);
    end
    ifa.seed_valid = 1'b0;
    ifb.seed_valid = 1'b0;
    if (n == 8) begin
      if (sel) begin
        mb[0] = w[63:0]; mb[1] = w[127:64]; mb[2] = w[191:128]; mb[3] = w[255:192];
        if (w == '0) mb[0] = ZF;
      end else begin
        ma[0] = w[63:0]; ma[1] = w[127:64]; ma[2] = w[191:128]; ma[3] = w[255:192];
        if (w == '0) ma[0] = ZF;
      end
    end
  endtask

  // One cycle with en=e; if enabled, push expected word (hand value or model).
  task automatic step(input bit sel, input bit e, input bit hand, input logic [63:0] hv);
    logic [63:0] r;
    exp_t        x;
    if (sel) ifb.en = e; else ifa.en = e;
    if (e) begin
      if (sel) xo(mb[0], mb[1], mb[2], mb[3], r);
      else     xo(ma[0], ma[1], ma[2], ma[3], r);
      x.cyc = cyc + 1;
      x.d   = hand ? hv : r;
      if (sel) qb.push_back(x); else qa.push_back(x);
    end
    @(posedge clk); #1;
    ifa.en = 1'b0;
    ifb.en = 1'b0;
  endtask

  initial begin
    logic [255:0] s1one;
    logic [255:0] seed_x;
    logic [255:0] seed_z;
    logic [63:0]  r;
    int           wc;
    bit           pat [5];

    s1one  = 256'd1 << 64;
    seed_x = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0;
    seed_z = 256'hDEADBEEF00000001_0000000000000000_CAFEF00D12345678_0000000000000002;
    pat    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rstn = 1'b0;
    ifa.seed_valid = 1'b0; ifa.seed_data = '0; ifa.en = 1'b0;
    ifb.seed_valid = 1'b0; ifb.seed_data = '0; ifb.en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", 64'(ifa.ready), 64'd0);
    chk("rst_a_valid", 64'(ifa.valid_out), 64'd0);
    chk("rst_a_data", ifa.data_out, 64'd0);
    chk("rst_b_ready", 64'(ifb.ready), 64'd0);
    chk("rst_a_s1", dut_a.s_q[1], 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    // en without a seed: nothing comes out.
    ifa.en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      chk("a_ready_unseeded", 64'(ifa.ready), 64'd0);
    end
    ifa.en = 1'b0;

    // s1=1 seed, WARMUP=0.
    seed(1'b0, s1one, 8);
    chk("a_ready_seeded", 64'(ifa.ready), 64'd1);
    step(1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_1680);
    chk("a_s0_step1", dut_a.s_q[0], 64'd1);
    chk("a_s1_step1", dut_a.s_q[1], 64'd1);
    chk("a_s2_step1", dut_a.s_q[2], 64'h20000);
    chk("a_s3_step1", dut_a.s_q[3], 64'h0000_2000_0000_0000);
    step(1'b0, 1'b1, 1'b1, 64'h0000_0000_0000_1680);
    step(1'b0, 1'b1, 1'b0, '0);

    // en pattern 1,0,1,1,0 in RUN.
    for (int i = 0; i < 5; i++) step(1'b0, pat[i], 1'b0, '0);

    // All-zero seed: s0 takes ZERO_FIX, first word 0, then a long run.
    seed(1'b0, '0, 8);
    chk("a_zero_fix_s0", dut_a.s_q[0], ZF);
    chk("a_zero_fix_s1", dut_a.s_q[1], 64'd0);
    step(1'b0, 1'b1, 1'b1, 64'd0);
    step(1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    checks++;
    if (ifa.data_out == 64'd0) begin
      errors++;
      $display("FAIL a_zero_seed_second_word: got %h expected nonzero", ifa.data_out);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 998; i++) step(1'b0, 1'b1, 1'b0, '0);

    // WARMUP=16 instance: ready exactly 16 cycles after the 8th word.
    seed(1'b1, s1one, 8);
    wc = 0;
    while (!ifb.ready && wc < 40) begin
      @(posedge clk); #1;
      wc++;
    end
    chk("b_warm_latency", 64'(wc), 64'd16);
    for (int i = 0; i < 16; i++) xo(mb[0], mb[1], mb[2], mb[3], r);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Reseed during RUN with en held high.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0);
    ifa.en = 1'b1;
    seed(1'b0, seed_x, 8);
    ifa.en = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, '0);

    // Reset in the middle of a load discards the partial seed.
    seed(1'b0, seed_z, 3);
    rstn = 1'b0;
    @(negedge clk);
    chk("midload_rst_ready", 64'(ifa.ready), 64'd0);
    chk("midload_rst_valid", 64'(ifa.valid_out), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    ifa.en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("a_ready_after_rst", 64'(ifa.ready), 64'd0);
    end
    ifa.en = 1'b0;
    seed(1'b0, seed_z, 8);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, '0);

    repeat (3) @(posedge clk);
    #1;
    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    chk("b_queue_drained", 64'(qb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
